// File: rtl/exec_sequencer_pkg.sv
// exec_sequencer_pkg
//   Shared definitions for the instruction sequencer and the external ALU:
//   sequencer state encoding and the 3-bit ALU select codes.
package exec_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } seq_state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_NOT = 3'd4,
    OP_XOR = 3'd5,
    OP_SHL = 3'd6
  } alu_op_e;

  localparam int DATA_W = 8;

endpackage

// File: rtl/exec_sequencer_regfile.sv
// regfile
//   2**REG_ADDR_W x 8-bit register file.
//   Ports:
//     clk, rst            clock, synchronous active-high reset (clears all)
//     we, waddr, wdata    single synchronous write port
//     raddr_a / rdata_a   combinational read port A
//     raddr_b / rdata_b   combinational read port B
//     dbg_sel / dbg_data  combinational debug read port
module regfile
  import exec_sequencer_pkg::*;
#(
  parameter int REG_ADDR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0]     rdata_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0]     rdata_b,
  input  logic [REG_ADDR_W-1:0] dbg_sel,
  output logic [DATA_W-1:0]     dbg_data
);

  localparam int NUM_REGS = 1 << REG_ADDR_W;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer
//   Four-phase (IDLE/READ/EXEC/WRITE) instruction sequencer driving an
//   external combinational ALU and owning a small register file.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     in_valid / in_ready      instruction handshake (ready only in IDLE)
//     in_op, in_rd, in_rs,     instruction fields, captured on acceptance
//     in_rt, in_use_imm, in_imm
//     alu_a, alu_b, alu_s      registered ALU operands/select (set end of READ)
//     alu_out                  ALU result, captured at end of EXEC
//     done, result             one-cycle completion pulse and written value
//     zero                     sticky: last written result was zero
//     dbg_sel / dbg_data       combinational register-file peek
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int REG_ADDR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [REG_ADDR_W-1:0] in_rs,
  input  logic [REG_ADDR_W-1:0] in_rt,
  input  logic                  in_use_imm,
  input  logic [7:0]            in_imm,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic [2:0]            alu_s,
  input  logic [7:0]            alu_out,
  output logic                  done,
  output logic [7:0]            result,
  output logic                  zero,
  input  logic [REG_ADDR_W-1:0] dbg_sel,
  output logic [7:0]            dbg_data
);

  seq_state_e            state;
  logic [2:0]            op_q;
  logic [REG_ADDR_W-1:0] rd_q, rs_q, rt_q;
  logic                  use_imm_q;
  logic [7:0]            imm_q;
  logic [7:0]            rdata_a, rdata_b;
  logic                  rf_we;

  // Gate the write with rst so a reset landing in WRITE aborts the store.
  assign rf_we    = (state == ST_WRITE) && !rst;
  assign in_ready = (state == ST_IDLE);

  regfile #(.REG_ADDR_W(REG_ADDR_W)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (rd_q),
    .wdata    (result),
    .raddr_a  (rs_q),
    .rdata_a  (rdata_a),
    .raddr_b  (rt_q),
    .rdata_b  (rdata_b),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s     <= '0;
      result    <= '0;
      done      <= 1'b0;
      zero      <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q      <= in_op;
            rd_q      <= in_rd;
            rs_q      <= in_rs;
            rt_q      <= in_rt;
            use_imm_q <= in_use_imm;
            imm_q     <= in_imm;
            state     <= ST_READ;
          end
        end
        ST_READ: begin
          alu_a <= rdata_a;
          alu_b <= use_imm_q ? imm_q : rdata_b;
          alu_s <= op_q;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          // Result, flag and pulse all become visible for the WRITE cycle.
          result <= alu_out;
          zero   <= (alu_out == 8'd0);
          done   <= 1'b1;
          state  <= ST_WRITE;
        end
        ST_WRITE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
